// File: rtl/connect4_pkg.sv
// connect4_pkg: board geometry, detector status codes, move-controller states and cell indexing.
package connect4_pkg;
    localparam logic [1:0] STILL_PLAYING = 2'b00;
    localparam logic [1:0] P1_WINS       = 2'b01;
    localparam logic [1:0] P2_WINS       = 2'b10;
    localparam logic [1:0] TIE           = 2'b11;
    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int BOARD_W = ROWS * COLS;
    typedef enum logic [1:0] {S_IDLE, S_DROP, S_COMMIT, S_SETTLE} state_e;
    function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
        return {r, c};
    endfunction
endpackage

// File: rtl/connect4_move_ctrl_drop_tick_counter.sv
// drop_tick_counter: modulo-N tick counter with synchronous clear and terminal-count flag.
module drop_tick_counter #(
    parameter int N = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int W = $clog2(N + 1);
    logic [W-1:0] cnt_q;
    assign tc_o = cnt_q == W'(N - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i)  cnt_q <= tc_o ? '0 : cnt_q + 1'b1;
    end
endmodule

// File: rtl/connect4_move_ctrl.sv
// connect4_move_ctrl: accepts column moves, animates the falling piece, commits it and alternates turns.
module connect4_move_ctrl
    import connect4_pkg::*;
#(
    parameter int DROP_TICKS = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_game,
    input  logic               move_valid,
    input  logic [1:0]         move_col,
    output logic               move_ready,
    input  logic [1:0]         game_status,
    output logic [BOARD_W-1:0] game_board,
    output logic [BOARD_W-1:0] player_cells,
    output logic               current_player,
    output logic [BOARD_W-1:0] falling_cell,
    output logic               move_done,
    output logic               move_err
);
    state_e             state_q, state_d;
    logic [1:0]         r_q, r_d, c_q, c_d;
    logic [BOARD_W-1:0] board_q, board_d, pc_q, pc_d, fall_q, fall_d;
    logic               cur_q, cur_d, done_q, done_d, err_q, err_d, settle_q, settle_d;
    logic               tick_clr, tick_tc;

    drop_tick_counter #(.N(DROP_TICKS)) u_tick (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (tick_clr),
        .en_i  (state_q == S_DROP),
        .tc_o  (tick_tc)
    );

    assign move_ready     = (state_q == S_IDLE) && (game_status == STILL_PLAYING);
    assign game_board     = board_q;
    assign player_cells   = pc_q;
    assign current_player = cur_q;
    assign falling_cell   = fall_q;
    assign move_done      = done_q;
    assign move_err       = err_q;

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        c_d      = c_q;
        board_d  = board_q;
        pc_d     = pc_q;
        cur_d    = cur_q;
        fall_d   = fall_q;
        settle_d = settle_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tick_clr = 1'b0;
        if (new_game) begin
            state_d  = S_IDLE;
            board_d  = '0;
            pc_d     = '0;
            cur_d    = 1'b0;
            fall_d   = '0;
            tick_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (move_valid && move_ready) begin
                    if (board_q[idx(2'(ROWS - 1), move_col)]) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = S_DROP;
                        c_d      = move_col;
                        r_d      = 2'(ROWS - 1);
                        tick_clr = 1'b1;
                        fall_d   = BOARD_W'(1) << idx(2'(ROWS - 1), move_col);
                    end
                end
                // The piece keeps falling only while the cell below it is free.
                S_DROP: if (tick_tc) begin
                    if (r_q != 2'd0 && !board_q[idx(r_q - 2'd1, c_q)]) begin
                        r_d    = r_q - 2'd1;
                        fall_d = BOARD_W'(1) << idx(r_q - 2'd1, c_q);
                    end else begin
                        state_d = S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    board_d[idx(r_q, c_q)] = 1'b1;
                    pc_d[idx(r_q, c_q)]    = cur_q;
                    cur_d    = ~cur_q;
                    fall_d   = '0;
                    done_d   = 1'b1;
                    settle_d = 1'b0;
                    state_d  = S_SETTLE;
                end
                S_SETTLE: begin
                    settle_d = 1'b1;
                    state_d  = settle_q ? S_IDLE : S_SETTLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            r_q      <= '0;
            c_q      <= '0;
            board_q  <= '0;
            pc_q     <= '0;
            fall_q   <= '0;
            cur_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            settle_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            c_q      <= c_d;
            board_q  <= board_d;
            pc_q     <= pc_d;
            fall_q   <= fall_d;
            cur_q    <= cur_d;
            done_q   <= done_d;
            err_q    <= err_d;
            settle_q <= settle_d;
        end
    end
endmodule

// File: tb/tb_connect4_move_ctrl.sv
// tb_connect4_move_ctrl: directed checks of the move controller at DROP_TICKS=1 and DROP_TICKS=3.
module tb_connect4_move_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        new_game = 1'b0;
    logic [1:0]  game_status = 2'b00;
    logic        mv1 = 1'b0, mv3 = 1'b0;
    logic [1:0]  col1 = 2'd0, col3 = 2'd0;
    logic        rdy1, rdy3, cur1, cur3, done1, done3, err1, err3;
    logic [15:0] brd1, brd3, pc1, pc3, fall1, fall3;
    int          n_cmp = 0, n_err = 0;
    int          lat;
    logic        seen;

    always #5 clk = ~clk;

    connect4_move_ctrl #(.DROP_TICKS(1)) dut1 (
        .clk(clk), .reset(reset), .new_game(new_game), .move_valid(mv1), .move_col(col1),
        .move_ready(rdy1), .game_status(game_status), .game_board(brd1), .player_cells(pc1),
        .current_player(cur1), .falling_cell(fall1), .move_done(done1), .move_err(err1)
    );

    connect4_move_ctrl #(.DROP_TICKS(3)) dut3 (
        .clk(clk), .reset(reset), .new_game(1'b0), .move_valid(mv3), .move_col(col3),
        .move_ready(rdy3), .game_status(2'b00), .game_board(brd3), .player_cells(pc3),
        .current_player(cur3), .falling_cell(fall3), .move_done(done3), .move_err(err3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake on dut1, then count cycles until move_done (bounded), then finish SETTLE.
    task automatic move1(input logic [1:0] c, output int l);
        mv1 = 1'b1;
        col1 = c;
        step();
        mv1 = 1'b0;
        l = 1;
        while (!done1 && l < 40) begin
            step();
            l++;
        end
        step();
        step();
    endtask

    initial begin
        step();
        chk("rst_board", brd1, 16'h0);
        chk("rst_pc", pc1, 16'h0);
        chk("rst_fall", fall1, 16'h0);
        chk("rst_cur", cur1, 1'b0);
        chk("rst_done_err", {done1, err1}, 2'b00);
        chk("rst_ready", rdy1, 1'b1);
        reset = 1'b1;
        step();

        // DROP_TICKS=3, column 3: each position held 3 cycles, 12 DROP cycles.
        mv3 = 1'b1;
        col3 = 2'd3;
        step();
        mv3 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("dt3_fall_%0d", k), fall3, 32'h1 << (15 - 4 * (k / 3)));
            step();
        end
        chk("dt3_commit_fall", fall3, 16'h0008);
        step();
        chk("dt3_done", done3, 1'b1);
        chk("dt3_board", brd3, 16'h0008);

        // First move col 0 on dut1.
        mv1 = 1'b1;
        col1 = 2'd0;
        step();
        mv1 = 1'b0;
        chk("m1_fall_r3", fall1, 16'h1000);
        chk("m1_ready_busy", rdy1, 1'b0);
        step();
        chk("m1_fall_r2", fall1, 16'h0100);
        step();
        chk("m1_fall_r1", fall1, 16'h0010);
        step();
        chk("m1_fall_r0", fall1, 16'h0001);
        step();
        chk("m1_commit_nodone", done1, 1'b0);
        step();
        chk("m1_done", done1, 1'b1);
        chk("m1_board", brd1, 16'h0001);
        chk("m1_pc", pc1, 16'h0000);
        chk("m1_cur", cur1, 1'b1);
        chk("m1_fall_idle", fall1, 16'h0);
        step();
        chk("m1_done_pulse", done1, 1'b0);
        step();
        chk("m1_ready_again", rdy1, 1'b1);

        // Second move col 0 lands on row 1 after 3 DROP cycles.
        move1(2'd0, lat);
        chk("m2_latency", lat, 5);
        chk("m2_board", brd1, 16'h0011);
        chk("m2_pc", pc1, 16'h0010);
        chk("m2_cur", cur1, 1'b0);

        // Fresh board, fill column 2, then a rejected request.
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        chk("ng_board", brd1, 16'h0);
        for (int k = 0; k < 4; k++) begin
            move1(2'd2, lat);
            chk($sformatf("fill_lat_%0d", k), lat, 6 - k);
        end
        chk("full_board", brd1, 16'h4444);
        chk("full_pc", pc1, 16'h4040);
        mv1 = 1'b1;
        col1 = 2'd2;
        step();
        mv1 = 1'b0;
        chk("err_pulse", err1, 1'b1);
        chk("err_ready", rdy1, 1'b1);
        chk("err_fall", fall1, 16'h0);
        step();
        chk("err_once", err1, 1'b0);
        chk("err_board", brd1, 16'h4444);
        chk("err_cur", cur1, 1'b0);

        // Game over: moves ignored.
        game_status = 2'b01;
        #1;
        chk("over_ready", rdy1, 1'b0);
        mv1 = 1'b1;
        col1 = 2'd1;
        step();
        mv1 = 1'b0;
        chk("over_noerr", err1, 1'b0);
        chk("over_nodrop", fall1, 16'h0);
        step();
        chk("over_board", brd1, 16'h4444);
        game_status = 2'b00;
        #1;
        chk("play_ready", rdy1, 1'b1);

        // new_game during DROP.
        move1(2'd0, lat);
        chk("pre_ng_cur", cur1, 1'b1);
        mv1 = 1'b1;
        col1 = 2'd1;
        step();
        mv1 = 1'b0;
        step();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        chk("ngd_board", brd1, 16'h0);
        chk("ngd_pc", pc1, 16'h0);
        chk("ngd_cur", cur1, 1'b0);
        chk("ngd_fall", fall1, 16'h0);
        chk("ngd_ready", rdy1, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            seen |= done1;
            step();
        end
        chk("ngd_nodone", seen, 1'b0);

        // Asynchronous reset during DROP.
        move1(2'd0, lat);
        mv1 = 1'b1;
        col1 = 2'd3;
        step();
        mv1 = 1'b0;
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("rstd_board", brd1, 16'h0);
        chk("rstd_pc", pc1, 16'h0);
        chk("rstd_cur", cur1, 1'b0);
        chk("rstd_fall", fall1, 16'h0);
        chk("rstd_ready", rdy1, 1'b1);
        step();
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            seen |= done1;
        end
        chk("rstd_nodone", seen, 1'b0);
        chk("rstd_ready2", rdy1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/connect4_move_ctrl.md
# connect4_move_ctrl

Writer side of the 4x4 board interface: accepts column selections from the player input logic, animates the piece falling down the chosen column, commits it to the lowest empty cell, and alternates turns. It owns and drives `game_board` and `player_cells`, which the winner detector consumes. It reads the detector's `game_status` back to block moves once the game is over.

## Interface
- `DROP_TICKS`, default 1: cycles the falling piece spends in each row; minimum 1.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous reset, active-low.
- `new_game`  in  1  synchronous clear of board and turn; valid in any state.
- `move_valid`  in  1  a column request is present.
- `move_col`  in  2  requested column, 0..3.
- `move_ready`  out  1  block can accept a move this cycle.
- `game_status`  in  2  from the detector: 00 still playing, 01 P1 wins, 10 P2 wins, 11 tie.
- `game_board`  out  16  occupancy; bit `4*r+c`, row 0 = bottom, row 3 = top.
- `player_cells`  out  16  owner of each occupied cell: 1 = P2, 0 = P1; always 0 where `game_board` is 0.
- `current_player`  out  1  whose turn it is: 0 = P1, 1 = P2.
- `falling_cell`  out  16  one-hot position of the piece in flight; 0 when idle.
- `move_done`  out  1  one-cycle pulse after a piece is committed.
- `move_err`  out  1  one-cycle pulse when a move into a full column is rejected.

## Operation
- States:
  - IDLE: waiting for a move.
  - DROP: piece in flight; row counter `r` and tick counter active.
  - COMMIT: write the piece into the board.
  - SETTLE: 2 cycles, covering the detector's registered latency.
- `move_ready` = (state == IDLE) && (`game_status` == 00). It is combinational.
- Handshake completes on `move_valid && move_ready` at a rising edge.
- Column full (`game_board[12+move_col]` == 1):
  - stay in IDLE;
  - `move_err` is high for the next cycle;
  - board and turn are unchanged.
- Otherwise, go to DROP:
  - latch the column `c`;
  - set `r` = 3 and the tick counter to 0;
  - `falling_cell` = bit `4*r+c`.
- In DROP:
  - the tick counter counts 0..DROP_TICKS-1;
  - on the terminal tick, if `r` > 0 and `game_board[4*(r-1)+c]` == 0, decrement `r` and reset the tick counter;
  - otherwise go to COMMIT.
- In COMMIT:
  - set `game_board[4*r+c]`;
  - set `player_cells[4*r+c]` = `current_player`;
  - toggle `current_player`;
  - clear `falling_cell`;
  - go to SETTLE.
- `move_done` is high for the first SETTLE cycle.
- After SETTLE, return to IDLE.
- `move_valid` outside IDLE, or while the game is over, is ignored. It produces no `move_err`.
- `new_game`:
  - clears `game_board`, `player_cells`, `falling_cell` and `current_player`;
  - suppresses `move_done` and `move_err`;
  - forces IDLE;
  - takes priority over a simultaneous handshake.
- A tie (full board) needs no special handling: the detector reports 11, and `move_ready` drops.

## Timing
- Reset values: state IDLE; `game_board`, `player_cells`, `falling_cell` = 0; `current_player` = 0; `move_done`, `move_err` = 0.
- `move_ready` follows `game_status` immediately after reset.
- Landing row L: DROP lasts (4-L)*DROP_TICKS cycles.
- Example, DROP_TICKS=1, empty column, handshake at edge T:
  - DROP for cycles T+1..T+4;
  - COMMIT in cycle T+5;
  - board updated and `move_done` high in cycle T+6;
  - SETTLE in T+6..T+7;
  - `move_ready` high again in T+8.
- `move_err` is high in cycle T+1 after the rejected handshake at T; `move_ready` stays high.
- Reset asserted mid-DROP: the piece is discarded and every output takes its reset value asynchronously.
- All outputs except `move_ready` are registered.

## Structure
- Shared package `connect4_pkg`:
  - status encodings STILL_PLAYING/P1_WINS/P2_WINS/TIE;
  - ROWS=4, COLS=4, BOARD_W=16;
  - cell index function `idx(r,c)=4*r+c`;
  - state enum.
- The winner detector imports the same status constants.
- Optional sub-module `drop_tick_counter`: modulo-DROP_TICKS counter with clear and terminal-count output, width $clog2(DROP_TICKS+1).
- All other logic is flat in this module.

## Test plan
- Reset, then move col 0 with DROP_TICKS=1:
  - `falling_cell` steps 0x1000, 0x0100, 0x0010, 0x0001;
  - `game_board` = 0x0001, `player_cells` = 0x0000;
  - `move_done` high 6 cycles after the handshake;
  - `current_player` = 1.
- Second move col 0:
  - lands at row 1;
  - `game_board` = 0x0011, `player_cells` = 0x0010;
  - DROP lasts 3 cycles.
- Fill col 2 (4 moves), then request col 2:
  - `move_err` pulses for exactly one cycle;
  - `game_board` = 0x4444 is unchanged;
  - `current_player` is unchanged.
- Drive `game_status`=01 in IDLE:
  - `move_ready` = 0;
  - `move_valid` with col 1 produces no DROP and no `move_err`.
- DROP_TICKS=3, col 3 on empty board: DROP lasts 12 cycles; each `falling_cell` position is held 3 cycles.
- Assert `new_game` during DROP, and separately `reset`=0 during DROP:
  - both clear the board to 0x0000, `player_cells` to 0x0000, `current_player` to 0;
  - no `move_done` pulse;
  - `move_ready` is high on the next cycle.
